iram_axi_arb: RTL and testbench
===============================

IRAM_AXI_ARB -- requirements
Module: iram_axi_arb

Interface
REQ-001 Parameter AW, 32, address width of requester and AXI address ports.
REQ-002 Parameter DW, 32, data width; wstrb width is DW/8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mN_req  input  1  requester N (N=0 core LSU, N=1 debug/loader) access request; held high until mN_ack.
REQ-006 mN_we  input  1  1=write, 0=read; stable while mN_req high.
REQ-007 mN_addr  input  AW  byte address; stable while mN_req high.
REQ-008 mN_wdata  input  DW  write data.
REQ-009 mN_wstrb  input  DW/8  byte strobes.
REQ-010 mN_ack  output  1  one-cycle completion pulse.
REQ-011 mN_rdata  output  DW  read data; valid with mN_ack for reads, held until that master's next read ack.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 AXI4-Lite master toward iram slave: awaddr/araddr output AW; awprot/arprot output 3 (constant 0); awvalid, wvalid, arvalid, bready, rready output 1; wdata output DW; wstrb output DW/8; awready, wready, arready, bvalid, rvalid input 1; rdata input DW; bresp/rresp input 2 (ignored).

Function
REQ-014 FSM states IDLE, WR, WB, RD, RR, all outputs registered except busy.
REQ-015 IDLE: on any unmasked request, latch winner index, addr, wdata, wstrb, we; next state WR if we else RD.
REQ-016 A requester whose mN_ack is high this cycle is masked in IDLE (prevents double issue).
REQ-017 WR: awvalid and wvalid both high, same addr/data, until awready&wready both sampled high in the same cycle; then WB. awvalid/wvalid never asserted individually.
REQ-018 WB: bready=1; on bvalid go IDLE and pulse winner ack next cycle.
REQ-019 RD: arvalid=1 until arready; then RR.
REQ-020 RR: rready=1; on rvalid capture rdata into winner mN_rdata, pulse winner ack, go IDLE.
REQ-021 Latency with always-ready slave: req sampled cycle 0, valid cycle 1, resp handshake cycle 2, ack cycle 3; new grant possible cycle 3.
REQ-022 Exactly one transaction outstanding; at most one ack high per cycle; non-winner's req is never dropped, only delayed.
REQ-023 AXI address ports carry the latched address unmodified (slave drops [1:0]); unused channel address outputs hold last value.

Reset
REQ-024 rst high at a clock edge: state IDLE, all valid/ready outputs 0, mN_ack 0, mN_rdata 0, latched addr/data 0, RR pointer selects m0.
REQ-025 Reset mid-transaction aborts it with no ack; valids deassert on the reset edge.

Configuration
REQ-026 Macro IRAM_ARB_RR_EN defined: round-robin; on simultaneous requests the master not granted last wins; pointer updates on each grant.
REQ-027 Macro undefined: fixed priority, m1 always wins simultaneous requests; no pointer register.

Verification
REQ-028 m0 write addr 0x10 data 0xDEADBEEF wstrb 0xF, slave always ready -> awvalid&wvalid cycle 1, bready cycle 2, m0_ack cycle 3 only; subsequent m0 read 0x10 returns 0xDEADBEEF with m0_ack.
REQ-029 m0 and m1 read requests same cycle, held -> RR build: m0 served first (ack cycle 3), m1 second (ack cycle 6); fixed build: m1 first, m0 second.
REQ-030 Slave wready delayed 3 cycles while awready immediate -> awvalid/wvalid stay high and address stable until joint handshake; single ack.
REQ-031 rvalid delayed 4 cycles -> rready held, busy high, ack exactly one cycle after rvalid; mN_rdata holds value afterwards.
REQ-032 rst asserted during WB -> next cycle IDLE, all valids 0, no ack; request still high is re-granted after rst release.

Source files
------------

// File: rtl/iram_axi_arb_if.sv
// iram_axi_arb_if -- bundle of the two requester ports, the busy flag and the
// AXI4-Lite master channels of the IRAM arbiter.
// The "master" modport is the arbiter's own view: it serves the requesters
// and masters the AXI bus. The "slave" modport is everything around it:
// the two requesters plus the IRAM AXI slave.
interface iram_axi_arb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // requester 0 (core LSU)
   logic            m0_req;
   logic            m0_we;
   logic [AW-1:0]   m0_addr;
   logic [DW-1:0]   m0_wdata;
   logic [DW/8-1:0] m0_wstrb;
   logic            m0_ack;
   logic [DW-1:0]   m0_rdata;

   // requester 1 (debug / loader)
   logic            m1_req;
   logic            m1_we;
   logic [AW-1:0]   m1_addr;
   logic [DW-1:0]   m1_wdata;
   logic [DW/8-1:0] m1_wstrb;
   logic            m1_ack;
   logic [DW-1:0]   m1_rdata;

   logic            busy;

   // AXI4-Lite toward the IRAM slave
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      output m1_ack, m1_rdata,
      output busy,
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      input  m1_ack, m1_rdata,
      input  busy,
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/iram_axi_arb.sv
// iram_axi_arb -- two-requester arbiter in front of an AXI4-Lite IRAM slave.
// One transaction outstanding at a time; every output except busy is a flop.
// Optional feature: define IRAM_ARB_RR_EN for round-robin arbitration.
// Without it, requester 1 (debug/loader) wins simultaneous requests.
module iram_axi_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic            clk,
   input logic            rst,
   iram_axi_arb_if.master bus
);
   localparam int SW = DW / 8;

   typedef enum logic [2:0] {IDLE, WR, WB, RD, RR} state_t;

   state_t          state_q, state_d;
   logic            win_q, win_d;
   logic [AW-1:0]   awaddr_q, awaddr_d;
   logic [AW-1:0]   araddr_q, araddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            wr_valid_q, wr_valid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            ack0_q, ack0_d;
   logic            ack1_q, ack1_d;
   logic [DW-1:0]   rdata0_q, rdata0_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;

   logic            req0;
   logic            req1;
   logic            pick1;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic [SW-1:0]   sel_wstrb;
   logic            unused_resp;

   // a requester that is being acked this cycle still shows req high; mask it
   assign req0 = bus.m0_req & ~ack0_q;
   assign req1 = bus.m1_req & ~ack1_q;

`ifdef IRAM_ARB_RR_EN
   logic last_q, last_d;

   // last_q = 1 means m1 was granted last, so m0 takes a tie
   assign pick1 = req1 & (~req0 | ~last_q);
`else
   assign pick1 = req1;
`endif

   assign sel_we    = pick1 ? bus.m1_we    : bus.m0_we;
   assign sel_addr  = pick1 ? bus.m1_addr  : bus.m0_addr;
   assign sel_wdata = pick1 ? bus.m1_wdata : bus.m0_wdata;
   assign sel_wstrb = pick1 ? bus.m1_wstrb : bus.m0_wstrb;

   // the slave response codes carry nothing this arbiter acts on
   assign unused_resp = ^{bus.bresp, bus.rresp};

   // next-state and registered-output logic; the state itself records the
   // direction of the latched request, so no separate we flop is kept
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wr_valid_d = wr_valid_q;
      bready_d   = bready_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
`ifdef IRAM_ARB_RR_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               win_d = pick1;
`ifdef IRAM_ARB_RR_EN
               last_d = pick1;
`endif
               if (sel_we) begin
                  state_d    = WR;
                  awaddr_d   = sel_addr;
                  wdata_d    = sel_wdata;
                  wstrb_d    = sel_wstrb;
                  wr_valid_d = 1'b1;
               end else begin
                  state_d   = RD;
                  araddr_d  = sel_addr;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR: begin
            if (bus.awready & bus.wready) begin
               state_d    = WB;
               wr_valid_d = 1'b0;
               bready_d   = 1'b1;
            end
         end
         WB: begin
            if (bus.bvalid) begin
               state_d  = IDLE;
               bready_d = 1'b0;
               ack0_d   = ~win_q;
               ack1_d   = win_q;
            end
         end
         RD: begin
            if (bus.arready) begin
               state_d   = RR;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RR: begin
            if (bus.rvalid) begin
               state_d  = IDLE;
               rready_d = 1'b0;
               ack0_d   = ~win_q;
               ack1_d   = win_q;
               if (win_q) begin
                  rdata1_d = bus.rdata;
               end else begin
                  rdata0_d = bus.rdata;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers with synchronous reset that also aborts
   // any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         win_q      <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wr_valid_q <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
`ifdef IRAM_ARB_RR_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wr_valid_q <= wr_valid_d;
         bready_q   <= bready_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
`ifdef IRAM_ARB_RR_EN
         last_q     <= last_d;
`endif
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.m0_ack   = ack0_q;
   assign bus.m1_ack   = ack1_q;
   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_rdata = rdata1_q;

   // AW and W share one valid flop so they can never be raised separately
   assign bus.awaddr  = awaddr_q;
   assign bus.awprot  = 3'b000;
   assign bus.awvalid = wr_valid_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign bus.wvalid  = wr_valid_q;
   assign bus.bready  = bready_q;
   assign bus.araddr  = araddr_q;
   assign bus.arprot  = 3'b000;
   assign bus.arvalid = arvalid_q;
   assign bus.rready  = rready_q;
endmodule

// File: tb/tb_iram_axi_arb.sv
// tb_iram_axi_arb -- scoreboard bench for iram_axi_arb.
// Expected acks (master, cycle, read data) are queued when a request is
// issued and compared as acks appear. Honours IRAM_ARB_RR_EN for ordering.
module tb_iram_axi_arb;
   typedef struct {
      int          master;
      bit          we;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   int          cyc;
   int          checks;
   int          errors;
   int          w_delay;
   int          r_delay;
   exp_t        sb[$];
   logic [31:0] mem [int];

   iram_axi_arb_if #(.AW(32), .DW(32)) bus ();

   iram_axi_arb #(.AW(32), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // free-running clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // absolute safety net in case something hangs outside a bounded wait
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // AXI slave model: awready follows awvalid, wready after w_delay cycles,
   // immediate bvalid/arready, rvalid after r_delay cycles; word memory
   initial begin : slave_model
      int          wcnt;
      int          rcnt;
      int          idx;
      logic [31:0] word;
      logic [31:0] rd_addr;
      wcnt = 0;
      rcnt = 0;
      rd_addr = 32'h0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = 32'h0;
      bus.rresp   = 2'b00;
      forever begin
         @(negedge clk);
         bus.awready = bus.awvalid;
         if (bus.wvalid) begin
            bus.wready = (wcnt >= w_delay);
            wcnt++;
         end else begin
            bus.wready = 1'b0;
            wcnt = 0;
         end
         if (bus.awvalid && bus.wvalid && bus.wready) begin
            idx = int'({2'b00, bus.awaddr[31:2]});
            word = mem.exists(idx) ? mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++) begin
               if (bus.wstrb[b]) word[b*8 +: 8] = bus.wdata[b*8 +: 8];
            end
            mem[idx] = word;
         end
         bus.bvalid  = bus.bready;
         bus.arready = bus.arvalid;
         if (bus.arvalid) rd_addr = bus.araddr;
         if (bus.rready) begin
            bus.rvalid = (rcnt >= r_delay);
            idx = int'({2'b00, rd_addr[31:2]});
            bus.rdata = (bus.rvalid && mem.exists(idx)) ? mem[idx] : 32'h0;
            rcnt++;
         end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = 32'h0;
            rcnt = 0;
         end
      end
   end

   // drive one requester's request fields and raise its req
   task automatic issue(input int m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
      if (m == 0) begin
         bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
         bus.m0_wstrb = wstrb; bus.m0_req = 1'b1;
      end else begin
         bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
         bus.m1_wstrb = wstrb; bus.m1_req = 1'b1;
      end
   endtask

   // consume acks until the scoreboard is empty; each ack is checked
   // against the queued master, cycle and read data; requesters drop req
   // on their ack; one spare cycle lets the ack pulse clear
   task automatic drain(input int budget);
      int   n;
      int   got;
      exp_t e;
      logic [31:0] rd;
      n = 0;
      while ((sb.size() != 0 || bus.m0_req || bus.m1_req) && n < budget) begin
         @(negedge clk);
         n++;
         if (bus.m0_ack || bus.m1_ack) begin
            checks++;
            got = bus.m1_ack ? 1 : 0;
            if (bus.m0_ack && bus.m1_ack) begin
               errors++;
               $display("[TB] FAIL dual_ack: m0_ack=1 m1_ack=1 at cycle %0d, required at most one", cyc);
            end else if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_ack: m%0d acked at cycle %0d, required no ack", got, cyc);
            end else begin
               e = sb.pop_front();
               if (got !== e.master) begin
                  errors++;
                  $display("[TB] FAIL ack_master: got m%0d, required m%0d", got, e.master);
               end
               checks++;
               if (cyc !== e.cyc) begin
                  errors++;
                  $display("[TB] FAIL ack_cycle: m%0d ack at cycle %0d, required %0d", got, cyc, e.cyc);
               end
               if (!e.we) begin
                  checks++;
                  rd = got ? bus.m1_rdata : bus.m0_rdata;
                  if (rd !== e.rdata) begin
                     errors++;
                     $display("[TB] FAIL ack_rdata: m%0d rdata %h, required %h", got, rd, e.rdata);
                  end
               end
            end
            if (bus.m0_ack) bus.m0_req = 1'b0;
            if (bus.m1_ack) bus.m1_req = 1'b0;
         end
      end
      if (sb.size() != 0 || bus.m0_req || bus.m1_req) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d acks still pending after %0d cycles, required 0", sb.size(), budget);
         sb.delete();
         bus.m0_req = 1'b0;
         bus.m1_req = 1'b0;
      end
      @(negedge clk);
   endtask

   // reset values of every output
   task automatic test_reset();
      rst = 1'b1;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0;
      bus.m0_wdata = 32'h0; bus.m0_wstrb = 4'h0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0;
      bus.m1_wdata = 32'h0; bus.m1_wstrb = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy);
      end
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_valids: aw/w/ar/b/r = %b, required 00000",
                  {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
      end
      checks++;
      if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin
         errors++; $display("[TB] FAIL reset_ack: got %b, required 00", {bus.m0_ack, bus.m1_ack});
      end
      checks++;
      if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin
         errors++; $display("[TB] FAIL reset_rdata: got %h %h, required 0 0", bus.m0_rdata, bus.m1_rdata);
      end
      checks++;
      if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot} !== 106'h0) begin
         errors++;
         $display("[TB] FAIL reset_latched: awaddr %h araddr %h wdata %h wstrb %h, required all 0",
                  bus.awaddr, bus.araddr, bus.wdata, bus.wstrb);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // m0 write then read-back with an always-ready slave, cycle-exact
   task automatic test_write_read();
      int k;
      k = cyc;
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      sb.push_back('{master: 0, we: 1'b1, rdata: 32'h0, cyc: k + 3});
      @(negedge clk);
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL wr_valid_c1: aw/w/ar = %b, required 110", {bus.awvalid, bus.wvalid, bus.arvalid});
      end
      checks++;
      if ({bus.awaddr, bus.wdata, bus.wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
         errors++;
         $display("[TB] FAIL wr_payload: addr %h data %h strb %h, required 00000010 deadbeef f",
                  bus.awaddr, bus.wdata, bus.wstrb);
      end
      @(negedge clk);
      checks++;
      if ({bus.bready, bus.awvalid, bus.wvalid, bus.busy} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL wb_c2: bready/aw/w/busy = %b, required 1001",
                  {bus.bready, bus.awvalid, bus.wvalid, bus.busy});
      end
      drain(20);

      k = cyc;
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'hDEADBEEF, cyc: k + 3});
      @(negedge clk);
      checks++;
      if ({bus.arvalid, bus.awvalid, bus.araddr} !== {2'b10, 32'h10}) begin
         errors++;
         $display("[TB] FAIL rd_c1: arvalid %b awvalid %b araddr %h, required 1 0 00000010",
                  bus.arvalid, bus.awvalid, bus.araddr);
      end
      checks++;
      if (bus.awaddr !== 32'h10) begin
         errors++; $display("[TB] FAIL awaddr_hold: got %h, required 00000010", bus.awaddr);
      end
      @(negedge clk);
      checks++;
      if ({bus.rready, bus.arvalid} !== 2'b10) begin
         errors++; $display("[TB] FAIL rr_c2: rready/arvalid = %b, required 10", {bus.rready, bus.arvalid});
      end
      drain(20);
   endtask

   // simultaneous reads: ordering depends on the arbitration build
   task automatic test_simultaneous();
      int k;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem[32'h20 >> 2] = 32'h11112222;
      mem[32'h24 >> 2] = 32'h33334444;
      k = cyc;
      issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h24, 32'h0, 4'h0);
`ifdef IRAM_ARB_RR_EN
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'h11112222, cyc: k + 3});
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h33334444, cyc: k + 6});
`else
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h33334444, cyc: k + 3});
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'h11112222, cyc: k + 6});
`endif
      drain(40);

      k = cyc;
      issue(1, 1'b0, 32'h24, 32'h0, 4'h0);
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h33334444, cyc: k + 3});
      drain(20);

      k = cyc;
      issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h24, 32'h0, 4'h0);
`ifdef IRAM_ARB_RR_EN
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'h11112222, cyc: k + 3});
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h33334444, cyc: k + 6});
`else
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h33334444, cyc: k + 3});
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'h11112222, cyc: k + 6});
`endif
      drain(40);
   endtask

   // wready held off three cycles: joint AW/W valid and stable address
   task automatic test_wready_delay();
      int k;
      w_delay = 3;
      k = cyc;
      issue(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'h3);
      sb.push_back('{master: 1, we: 1'b1, rdata: 32'h0, cyc: k + 6});
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata} !== {2'b11, 32'h40, 32'hCAFEF00D}) begin
            errors++;
            $display("[TB] FAIL wr_hold_c%0d: aw %b w %b addr %h data %h, required 1 1 00000040 cafef00d",
                     i, bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL wr_delay_wb: aw/w/bready = %b, required 001", {bus.awvalid, bus.wvalid, bus.bready});
      end
      drain(20);
      w_delay = 0;

      k = cyc;
      issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h0000F00D, cyc: k + 3});
      drain(20);
   endtask

   // rvalid held off four cycles: rready and busy held, data retained
   task automatic test_rvalid_delay();
      int k;
      r_delay = 4;
      mem[32'h50 >> 2] = 32'h5A5A1234;
      k = cyc;
      issue(0, 1'b0, 32'h50, 32'h0, 4'h0);
      sb.push_back('{master: 0, we: 1'b0, rdata: 32'h5A5A1234, cyc: k + 7});
      @(negedge clk);
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.rready, bus.busy, bus.m0_ack} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rr_wait_c%0d: rready/busy/ack = %b, required 110",
                     i, {bus.rready, bus.busy, bus.m0_ack});
         end
      end
      drain(20);
      r_delay = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.m0_rdata !== 32'h5A5A1234) begin
         errors++; $display("[TB] FAIL rdata_hold: got %h, required 5a5a1234", bus.m0_rdata);
      end
      k = cyc;
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
      sb.push_back('{master: 1, we: 1'b0, rdata: 32'h11112222, cyc: k + 3});
      drain(20);
      checks++;
      if (bus.m0_rdata !== 32'h5A5A1234) begin
         errors++; $display("[TB] FAIL rdata_other: m0_rdata %h after m1 read, required 5a5a1234", bus.m0_rdata);
      end
   endtask

   // reset during WB aborts without ack; held request is granted again
   task automatic test_reset_wb();
      int k;
      k = cyc;
      issue(0, 1'b1, 32'h60, 32'h01020304, 4'hF);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.bready !== 1'b1) begin
         errors++; $display("[TB] FAIL rst_wb_pre: bready %b at cycle %0d, required 1", bus.bready, cyc - k);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL rst_wb_idle: busy/aw/w/ar/b/r = %b, required 000000",
                  {bus.busy, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
      end
      checks++;
      if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin
         errors++; $display("[TB] FAIL rst_wb_ack: got %b, required 00", {bus.m0_ack, bus.m1_ack});
      end
      rst = 1'b0;
      sb.push_back('{master: 0, we: 1'b1, rdata: 32'h0, cyc: cyc + 3});
      drain(20);
   endtask

   // run all scenarios in order and print the summary
   initial begin
      checks = 0;
      errors = 0;
      w_delay = 0;
      r_delay = 0;
      rst = 1'b1;
      test_reset();
      test_write_read();
      test_simultaneous();
      test_wready_delay();
      test_rvalid_delay();
      test_reset_wb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
